// File: rtl/alu_serial_rx.sv
// Serial frame receiver for the ALU input path: deserialises 11-bit packets into
// N_OPERANDS operands plus a command, checks framing/count/CRC-4/opcode, one-entry output.
module alu_serial_rx #(
  parameter int N_OPERANDS = 2,
  parameter int OP_BYTES   = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                sin,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [N_OPERANDS*OP_BYTES*8-1:0]    out_operands,
  output logic [2:0]                          out_op,
  output logic [2:0]                          out_err,
  output logic                                overrun
);

  localparam int NB = N_OPERANDS * OP_BYTES;
  localparam int DW = NB * 8;
  localparam int CW = $clog2(NB + 2);

  typedef enum logic [2:0] {S_IDLE, S_TYPE, S_PAYLOAD, S_STOP, S_WAIT_HIGH} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_type_p0;
  logic [2:0]      r_bit_p0;
  logic [7:0]      r_shift_p0;
  logic [DW-1:0]   r_opsh_p0;
  logic [CW-1:0]   r_cnt_p0;
  logic [3:0]      r_crc_p0;
  logic            r_bad_p0;

  logic            r_vld_p1;
  logic [DW-1:0]   r_ops_p1;
  logic [2:0]      r_op_p1;
  logic [2:0]      r_err_p1;
  logic            r_ovr_p1;

  logic            w_frame_done;
  logic            w_crc_in;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_err_data;
  logic [2:0]      w_err;
  logic            w_load;

  // x^4+x+1, MSB first, direct form
  function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  function automatic logic [2:0] err_encode(input logic data_err, input logic crc_err,
                                            input logic [2:0] op);
    logic op_err;
    op_err = !((op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101));
    if (data_err)     return 3'b100;
    else if (crc_err) return 3'b010;
    else if (op_err)  return 3'b001;
    else              return 3'b000;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (!sin) w_state_nxt = S_TYPE;
      S_TYPE:      w_state_nxt = S_PAYLOAD;
      S_PAYLOAD:   if (r_bit_p0 == 3'd7) w_state_nxt = S_STOP;
      S_STOP:      w_state_nxt = sin ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (sin) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Command CRC coverage is the constant 1 followed by op: the leading payload 0 is replaced by 1
  assign w_crc_in     = (r_type_p0 && (r_bit_p0 == 3'd0)) ? 1'b1 : sin;
  assign w_frame_done = (r_state == S_STOP) && r_type_p0;
  assign w_cnt_nxt    = (r_cnt_p0 == CW'(NB + 1)) ? r_cnt_p0 : r_cnt_p0 + CW'(1);
  assign w_err_data   = r_bad_p0 || (r_cnt_p0 != CW'(NB)) || !sin;
  assign w_err        = err_encode(w_err_data, r_crc_p0 != r_shift_p0[3:0], r_shift_p0[6:4]);
  assign w_load       = w_frame_done && (!r_vld_p1 || out_ready);

  // p0: packet reception, frame accounting and running CRC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type_p0 <= 1'b0;
      r_bit_p0  <= '0;
      r_cnt_p0  <= '0;
      r_crc_p0  <= '0;
      r_bad_p0  <= 1'b0;
    end else begin
      case (r_state)
        S_TYPE: begin
          r_type_p0 <= sin;
          r_bit_p0  <= '0;
        end
        S_PAYLOAD: begin
          r_bit_p0 <= r_bit_p0 + 3'd1;
          if (!r_type_p0 || !r_bit_p0[2]) r_crc_p0 <= crc4_step(r_crc_p0, w_crc_in);
        end
        S_STOP: begin
          if (r_type_p0) begin
            r_cnt_p0 <= '0;
            r_crc_p0 <= '0;
            r_bad_p0 <= 1'b0;
          end else if (sin) begin
            r_cnt_p0 <= w_cnt_nxt;
            if (w_cnt_nxt > CW'(NB)) r_bad_p0 <= 1'b1;
          end else begin
            r_bad_p0 <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_PAYLOAD) r_shift_p0 <= {r_shift_p0[6:0], sin};
    if ((r_state == S_STOP) && !r_type_p0 && sin) r_opsh_p0 <= DW'({r_opsh_p0, r_shift_p0});
  end

  // p1: one-entry output register with valid/ready and overrun reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_ops_p1 <= '0;
      r_op_p1  <= '0;
      r_err_p1 <= '0;
      r_ovr_p1 <= 1'b0;
    end else begin
      r_ovr_p1 <= w_frame_done && r_vld_p1 && !out_ready;
      if (w_load) begin
        r_vld_p1 <= 1'b1;
        r_ops_p1 <= r_opsh_p0;
        r_op_p1  <= r_shift_p0[6:4];
        r_err_p1 <= w_err;
      end else if (r_vld_p1 && out_ready) begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid    = r_vld_p1;
  assign out_operands = r_ops_p1;
  assign out_op       = r_op_p1;
  assign out_err      = r_err_p1;
  assign overrun      = r_ovr_p1;

endmodule
